nn_result_serializer: RTL
=========================

Name: nn_result_serializer

Overview:
- Output-side companion to the NN `top` block. Where the stimulus side drives U0/U1/U2, this block reads the results.
- On a `start` pulse (NN inputs applied that cycle) it counts the NN pipeline latency, then captures Y0/Y1.
- It then streams the two 18-bit results out one word per beat over a valid/ready interface, for a UART/host bridge or a scoreboard.

Parameters:
DW, 18, result word width (matches Y0/Y1)
LATENCY, 4, cycles from `start` to Y0/Y1 valid; legal range 1..255
CNT_W, 8, latency counter width; must hold LATENCY-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse: NN inputs U0..U2 applied this cycle
Y0  in  DW  NN output 0 (signed two's complement fixed point)
Y1  in  DW  NN output 1
busy  out  1  high in WAIT or SEND
out_data  out  DW  current result word
out_idx  out  1  0 = Y0 word, 1 = Y1 word
out_last  out  1  high with the Y1 word
out_valid  out  1  stream valid
out_ready  in  1  downstream ready
overrun  out  1  sticky: a start was dropped
overrun_clr  in  1  clears overrun

Behaviour:
Interface:
- One clock, `clk`; reset is synchronous and active-high, port `reset`.
- On reset all outputs read 0: busy, out_data, out_idx, out_last, out_valid, overrun. FSM goes to IDLE, counter and capture registers clear.
- A reset asserted mid-WAIT or mid-SEND aborts the transaction; the partial frame is not resumed.

FSM states: IDLE, WAIT, SEND.
- IDLE: when `start`=1, load cnt=LATENCY-1 and go to WAIT. Otherwise stay.
- WAIT: while cnt!=0, decrement. When cnt==0, register Y0/Y1 into cap0/cap1 at that edge, set idx=0 and go to SEND.
- Capture timing: Y sampled at the edge LATENCY cycles after the start edge. For LATENCY=1, capture happens at the edge following start.

SEND:
- out_valid=1, out_data=cap[idx], out_idx=idx, out_last=(idx==1). All are registered outputs.
- A beat transfers when out_valid&&out_ready. idx 0 -> 1; idx 1 -> IDLE.
- While out_ready=0, out_data, out_idx and out_last stay stable and out_valid stays high. Valid never drops without a transfer.
- First out_valid appears the cycle after capture, so start-to-first-valid is LATENCY+1 cycles.

Back-to-back:
- A `start` in the same cycle as the final (idx=1) transfer is accepted and goes directly to WAIT with cnt=LATENCY-1. No IDLE cycle, no overrun.

Overrun:
- A `start` in WAIT, or in SEND other than the final-transfer cycle, is ignored and sets `overrun` at the next edge.
- overrun_clr clears it. If a set and a clear occur in the same cycle, set wins.

Data:
- Capture is a straight DW-bit copy; no width change, sign preserved.

Optional Feature:
NN_RESULT_RELU_EN:
- Defined: at capture, any Y with MSB=1 (negative) is stored as 0; non-negative values pass unchanged.
- Undefined: raw two's-complement capture.
- Capture timing and interface are identical in both builds.

Test Plan:
1. Reset held 5 cycles, then released -> all outputs 0, busy=0, FSM idle.
2. LATENCY=4; start at cycle t; Y0=18'h00263, Y1=18'h0041E held -> valid rises at t+5 with out_data=18'h00263, idx=0. With out_ready=1: next beat 18'h0041E, idx=1, last=1. busy=0 after.
3. Same as 2 with out_ready=0 for 3 cycles on beat 0 -> data 18'h00263 held stable, valid held; the transfer occurs the cycle ready rises.
4. start again at t+2 during WAIT -> overrun=1 at t+3 and the frame is unaffected. overrun_clr pulsed together with a new dropped start -> overrun stays 1.
5. start asserted in the final-transfer cycle -> no overrun; the second frame's valid rises LATENCY+1 cycles later.
6. Y0=18'h3FF9C (-100) with NN_RESULT_RELU_EN defined -> out_data=0; without the macro -> 18'h3FF9C. Reset asserted mid-SEND -> valid=0 the next cycle.

Source files
------------

// File: rtl/nn_result_serializer.sv
// nn_result_serializer: captures the NN outputs Y0/Y1 a fixed number of cycles
// after a start pulse, then streams them out as two words over valid/ready.
// Optional build macro: NN_RESULT_RELU_EN (clamp negative results to zero at capture).
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no transaction; waiting for start
// S_WAIT | down-counting the NN pipeline latency; capture when cnt hits 0
// S_SEND | presenting word idx (0 = Y0, 1 = Y1) until the downstream accepts it
module nn_result_serializer #(
    parameter int DW      = 18,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] Y0,
    input  logic [DW-1:0] Y1,
    output logic          busy,
    output logic [DW-1:0] out_data,
    output logic          out_idx,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    input  logic          overrun_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // The start edge itself counts as the first latency cycle, hence LATENCY-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    cap1_q, cap1_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             overrun_set;
    logic             final_beat;

    function automatic logic [DW-1:0] capture_word(input logic [DW-1:0] y);
`ifdef NN_RESULT_RELU_EN
        return y[DW-1] ? '0 : y;
`else
        return y;
`endif
    endfunction

    // Next-state and output-register computation for the capture/send sequence.
    // Word 0 is captured straight into out_data_q, so only Y1 needs its own holding register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap1_d      = cap1_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        overrun_set = 1'b0;
        final_beat  = out_valid_q && out_ready && out_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (start) begin
                    overrun_set = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_data_d  = capture_word(Y0);
                    cap1_d      = capture_word(Y1);
                    out_idx_d   = 1'b0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (start && !final_beat) begin
                    overrun_set = 1'b1;
                end
                if (out_ready) begin
                    if (!out_idx_q) begin
                        out_data_d = cap1_q;
                        out_idx_d  = 1'b1;
                        out_last_d = 1'b1;
                    end else begin
                        out_data_d  = '0;
                        out_idx_d   = 1'b0;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b0;
                        // A start on the final transfer chains straight into the next frame.
                        if (start) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set takes priority so a dropped start is never lost to a simultaneous clear.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap1_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap1_q      <= cap1_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
